shift_register: RTL and testbench
=================================

SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter RST_VAL, default '0, value loaded into Q on reset.
REQ-003 SHALL have port CK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-005 SHALL have port MODE  input  2  operation select (HOLD, SHL, SHR, LOAD).
REQ-006 SHALL have port SI  input  1  serial data input.
REQ-007 SHALL have port D  input  WIDTH  parallel load data.
REQ-008 SHALL have port Q  output  WIDTH  register contents.
REQ-009 SHALL have port SO  output  1  last bit shifted out (registered).
REQ-010 SHALL have port CNT  output  $clog2(WIDTH+1)  shifts since last load/reset.
REQ-011 SHALL have port DONE  output  1  high when CNT==WIDTH.

Function
REQ-012 HOLD: Q, SO, CNT SHALL be unchanged.
REQ-013 SHL: Q SHALL become {Q[WIDTH-2:0], SI}; SO SHALL become old Q[WIDTH-1].
REQ-014 SHR: Q SHALL become {SI, Q[WIDTH-1:1]}; SO SHALL become old Q[0].
REQ-015 LOAD: Q SHALL become D, CNT SHALL become 0, SO SHALL be unchanged.
REQ-016 Latency: Q, SO and CNT SHALL reflect the selected operation one CK edge after sampling; no combinational path from MODE, SI or D to any output.
REQ-017 CNT SHALL increment by 1 on each SHL or SHR while CNT<WIDTH, and SHALL saturate at WIDTH.
REQ-018 Shifting while CNT==WIDTH SHALL still shift Q and update SO; CNT SHALL stay WIDTH.
REQ-019 DONE SHALL be a combinational decode of CNT (CNT==WIDTH) and SHALL fall on the edge at which LOAD clears CNT.
REQ-020 LOAD while DONE=1 SHALL take priority over saturation: CNT=0, DONE=0 after the edge.
REQ-021 MODE SHALL be a 2-bit encoding in which every code is defined; there are no illegal codes.

Reset
REQ-022 RST=1 SHALL immediately force Q=RST_VAL, SO=0, CNT=0, DONE=0, independent of CK.
REQ-023 RST asserted mid-shift SHALL discard the operation in progress; the first edge after RST deasserts SHALL perform the MODE then present.
REQ-024 While RST=1, all CK edges SHALL be ignored.

Configuration
REQ-025 Macro SHIFT_REGISTER_ROTATE_EN, when defined, SHALL add input port ROT (1 bit); when ROT=1, SHL SHALL insert old Q[WIDTH-1] into Q[0] and SHR SHALL insert old Q[0] into Q[WIDTH-1], with SI ignored; SO and CNT SHALL behave exactly as in REQ-013 and REQ-014.
REQ-026 Without SHIFT_REGISTER_ROTATE_EN, port ROT SHALL not exist and SI SHALL always be the inserted bit.

Structure
REQ-027 Package shift_register_pkg SHALL hold typedef enum logic[1:0] mode_t {HOLD=2'b00, SHL=2'b01, SHR=2'b10, LOAD=2'b11} and the CNT-width function.
REQ-028 The saturating counter SHALL be a separate sub-module shift_cnt, with ports CK, RST, CLR, INC, CNT and DONE, and parameter MAX=WIDTH.

Verification (WIDTH=8, RST_VAL=0)
REQ-029 LOAD with D=8'hA5 -> Q=8'hA5, CNT=0, DONE=0 after one edge.
REQ-030 From Q=A5, SHL with SI=1 -> Q=8'h4B, SO=1, CNT=1. From Q=A5, SHR with SI=0 -> Q=8'h52, SO=1.
REQ-031 LOAD, then 9 consecutive SHL -> DONE rises after the 8th shift, CNT holds 8 after the 9th, and LOAD on the next edge -> CNT=0, DONE=0.
REQ-032 RST pulse between CK edges during shifting -> Q=0, SO=0, CNT=0 without waiting for CK.
REQ-033 With SHIFT_REGISTER_ROTATE_EN, from Q=A5, SHR with ROT=1 and SI=0 -> Q=8'hD2, SO=1, CNT=1.

Source files
------------

// File: rtl/shift_register_pkg.sv
// Shared types and helpers for the shift_register block.
// Holds the operation encoding and the counter-width function used to size
// the shift counter and its port.
package shift_register_pkg;

   // Operation select; all four codes are meaningful, none are illegal.
   typedef enum logic [1:0] {
      HOLD = 2'b00,
      SHL  = 2'b01,
      SHR  = 2'b10,
      LOAD = 2'b11
   } mode_t;

   // Bits needed to hold a count from 0 up to and including w.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/shift_cnt.sv
// Saturating shift counter for shift_register.
// Counts INC pulses from 0 up to MAX and sticks there; CLR wins over INC.
// DONE is a plain decode of the registered count.
module shift_cnt
   import shift_register_pkg::*;
#(
   parameter int MAX = 8
) (
   input  logic                        CK,
   input  logic                        RST,
   input  logic                        CLR,
   input  logic                        INC,
   output logic [cnt_width(MAX)-1:0]   CNT,
   output logic                        DONE
);

   localparam int CW = cnt_width(MAX);
   localparam logic [CW-1:0] MAX_C = CW'(MAX);

   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_q;

   // Next count: clear has priority, otherwise increment until saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (INC && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register, asynchronously cleared.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign CNT  = cnt_q;
   assign DONE = (cnt_q == MAX_C);

endmodule

// File: rtl/shift_register.sv
// Bidirectional shift register with parallel load, registered serial-out
// bit and a saturating count of shifts since the last load or reset.
// Optional feature macro: SHIFT_REGISTER_ROTATE_EN adds input ROT, which
// turns SHL/SHR into rotates (SI ignored while ROT=1).
module shift_register
   import shift_register_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                          CK,
   input  logic                          RST,
   input  logic [1:0]                    MODE,
   input  logic                          SI,
   input  logic [WIDTH-1:0]              D,
`ifdef SHIFT_REGISTER_ROTATE_EN
   input  logic                          ROT,
`endif
   output logic [WIDTH-1:0]              Q,
   output logic                          SO,
   output logic [cnt_width(WIDTH)-1:0]   CNT,
   output logic                          DONE
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;
   logic             so_d;
   logic             so_q;
   logic             inc_s;
   logic             clr_s;
   logic             ins_l_s;
   logic             ins_r_s;

   // Bit entering the register on each shift direction.
`ifdef SHIFT_REGISTER_ROTATE_EN
   always_comb begin
      ins_l_s = SI;
      ins_r_s = SI;
      if (ROT) begin
         ins_l_s = q_q[WIDTH-1];
         ins_r_s = q_q[0];
      end else begin
         ins_l_s = SI;
         ins_r_s = SI;
      end
   end
`else
   assign ins_l_s = SI;
   assign ins_r_s = SI;
`endif

   // Decode the operation into next data/serial-out state and counter controls.
   always_comb begin
      q_d   = q_q;
      so_d  = so_q;
      inc_s = 1'b0;
      clr_s = 1'b0;
      case (mode_t'(MODE))
         HOLD: begin
            q_d  = q_q;
            so_d = so_q;
         end
         SHL: begin
            q_d   = {q_q[WIDTH-2:0], ins_l_s};
            so_d  = q_q[WIDTH-1];
            inc_s = 1'b1;
         end
         SHR: begin
            q_d   = {ins_r_s, q_q[WIDTH-1:1]};
            so_d  = q_q[0];
            inc_s = 1'b1;
         end
         LOAD: begin
            q_d   = D;
            clr_s = 1'b1;
         end
         default: begin
            q_d  = q_q;
            so_d = so_q;
         end
      endcase
   end

   // Data and serial-out registers, asynchronously reset.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         q_q  <= RST_VAL;
         so_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         so_q <= so_d;
      end
   end

   shift_cnt #(
      .MAX (WIDTH)
   ) u_cnt (
      .CK   (CK),
      .RST  (RST),
      .CLR  (clr_s),
      .INC  (inc_s),
      .CNT  (CNT),
      .DONE (DONE)
   );

   assign Q  = q_q;
   assign SO = so_q;

endmodule

// File: tb/tb_shift_register.sv
// Directed testbench for shift_register (WIDTH=8, RST_VAL=0).
module tb_shift_register;
   import shift_register_pkg::*;

   logic       CK;
   logic       RST;
   logic [1:0] MODE;
   logic       SI;
   logic [7:0] D;
`ifdef SHIFT_REGISTER_ROTATE_EN
   logic       ROT;
`endif
   logic [7:0] Q;
   logic       SO;
   logic [3:0] CNT;
   logic       DONE;

   int total;
   int bad;

   shift_register #(
      .WIDTH   (8),
      .RST_VAL (8'h00)
   ) dut (
      .CK   (CK),
      .RST  (RST),
      .MODE (MODE),
      .SI   (SI),
      .D    (D),
`ifdef SHIFT_REGISTER_ROTATE_EN
      .ROT  (ROT),
`endif
      .Q    (Q),
      .SO   (SO),
      .CNT  (CNT),
      .DONE (DONE)
   );

   // Free-running clock, period 10.
   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   // Safety net against a stuck run.
   initial begin
      #100000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] eq, input logic eso,
                          input logic [3:0] ecnt, input logic edone);
      chk({tag, ".Q"},    64'(Q),    64'(eq));
      chk({tag, ".SO"},   64'(SO),   64'(eso));
      chk({tag, ".CNT"},  64'(CNT),  64'(ecnt));
      chk({tag, ".DONE"}, 64'(DONE), 64'(edone));
   endtask

   // Drive inputs on the falling edge, return 1 time unit after the rising edge.
   task automatic step(input mode_t m, input logic si, input logic [7:0] d);
      @(negedge CK);
      MODE = m;
      SI   = si;
      D    = d;
      @(posedge CK);
      #1;
   endtask

   logic [7:0] exp_q  [9];
   logic       exp_so [9];

   initial begin
      total = 0;
      bad   = 0;
      RST   = 1'b1;
      MODE  = LOAD;
      SI    = 1'b1;
      D     = 8'hFF;
`ifdef SHIFT_REGISTER_ROTATE_EN
      ROT   = 1'b0;
`endif
      #1;
      chk_all("reset0", 8'h00, 1'b0, 4'd0, 1'b0);
      // Edges during reset must be ignored even with LOAD of FF presented.
      repeat (3) @(posedge CK);
      #1;
      chk_all("reset_edges", 8'h00, 1'b0, 4'd0, 1'b0);
      @(negedge CK);
      RST = 1'b0;

      step(LOAD, 1'b0, 8'hA5);
      chk_all("load_a5", 8'hA5, 1'b0, 4'd0, 1'b0);
      step(SHL, 1'b1, 8'h00);
      chk_all("shl_si1", 8'h4B, 1'b1, 4'd1, 1'b0);

      step(LOAD, 1'b0, 8'hA5);
      chk_all("reload", 8'hA5, 1'b1, 4'd0, 1'b0);
      step(SHR, 1'b0, 8'h00);
      chk_all("shr_si0", 8'h52, 1'b1, 4'd1, 1'b0);
      step(HOLD, 1'b1, 8'hFF);
      chk_all("hold", 8'h52, 1'b1, 4'd1, 1'b0);

      // Nine left shifts from A5: SI=0 for the first eight, SI=1 on the ninth.
      exp_q  = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00, 8'h01};
      exp_so = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      step(LOAD, 1'b0, 8'hA5);
      chk("sat_load.CNT", 64'(CNT), 64'd0);
      for (int i = 0; i < 9; i++) begin
         step(SHL, (i == 8) ? 1'b1 : 1'b0, 8'h00);
         chk_all($sformatf("sat_shl%0d", i + 1), exp_q[i], exp_so[i],
                 (i < 8) ? 4'(i + 1) : 4'd8, (i >= 7) ? 1'b1 : 1'b0);
      end
      step(LOAD, 1'b1, 8'h3C);
      chk_all("load_after_done", 8'h3C, 1'b0, 4'd0, 1'b0);

      // Asynchronous reset between edges while shifting.
      step(SHL, 1'b1, 8'h00);
      chk_all("pre_rst_shl", 8'h79, 1'b0, 4'd1, 1'b0);
      MODE = SHR;
      SI   = 1'b1;
      #1;
      RST = 1'b1;
      #1;
      chk_all("async_rst", 8'h00, 1'b0, 4'd0, 1'b0);
      @(negedge CK);
      RST = 1'b0;
      @(posedge CK);
      #1;
      chk_all("post_rst_shr", 8'h80, 1'b0, 4'd1, 1'b0);

`ifdef SHIFT_REGISTER_ROTATE_EN
      step(LOAD, 1'b0, 8'hA5);
      ROT = 1'b1;
      step(SHR, 1'b0, 8'h00);
      chk_all("rot_shr", 8'hD2, 1'b1, 4'd1, 1'b0);
      ROT = 1'b0;
      step(LOAD, 1'b0, 8'hA5);
      ROT = 1'b1;
      step(SHL, 1'b0, 8'h00);
      chk_all("rot_shl", 8'h4B, 1'b1, 4'd1, 1'b0);
      ROT = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
